rv_dec_stage_mt: RTL and testbench

//  Registered, handshaked RV32I decode stage for the multithreaded core. Sits between fetch and

---
 rtl/rv_dec_pkg.sv | 70 +++++++
 rtl/rv_dec_stage_mt_if.sv | 63 ++++++
 rtl/rv_dec_ctrl.sv | 136 +++++++++++++
 rtl/rv_dec_stage_mt.sv | 141 ++++++++++++++
 tb/tb_rv_dec_stage_mt.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_dec_pkg.sv
// rv_dec_pkg: shared definitions for the RV32I decode stage.
//   - Base-ISA opcode values (OPC_*).
//   - The funct3/funct7 values that the legality checks need.
//   - MRET_WORD: the only SYSTEM encoding that is decoded as mret.
//   - ctrl_t: the control enables produced for one instruction.
//   - dec_t: a fully decoded instruction, with register indices already masked.
//   - hart_width(): width of a hart tag. It is at least 1 bit, even for a single hart.
//   - dec_nop(): the decoded form of addi x0,x0,0.
package rv_dec_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_PRIV    = 3'b000;
    localparam logic [2:0] F3_CSR_RSV = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] MRET_WORD = 32'h3020_0073;

    typedef struct packed {
        logic rs1_en;
        logic rs2_en;
        logic rd_wr;
        logic mem_en;
        logic mem_wr;
        logic csr_en;
        logic csr_wr;
        logic jump;
        logic branch;
        logic mret;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        ctrl_t       ctrl;
        logic [31:0] imm;
    } dec_t;

    function automatic int hart_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic dec_t dec_nop();
        dec_t d;
        d        = '0;
        d.opcode = OPC_OP_IMM;
        return d;
    endfunction

endpackage

// File: rtl/rv_dec_stage_mt_if.sv
// rv_dec_stage_mt_if: fetch-side and regfile-side handshake bundle of the decode stage.
//   Fetch side : in_valid, in_ready, in_inst, in_hart, in_pc.
//   Flush      : flush_hart is a per-hart kill mask.
//   Output side: out_valid, out_ready and every decoded out_* field.
// Modports:
//   slave  - the decode stage itself.
//   master - the environment that drives fetch and flush and consumes the output.
// Both sides use valid/ready handshakes. A beat transfers on a rising clock edge where
// valid && ready. Once valid is raised, the payload holds steady until that transfer happens.
// The only exception is a flush of the payload's hart, which withdraws the beat.
interface rv_dec_stage_mt_if #(
    parameter int NUM_HARTS = 4,
    parameter int XLEN      = 32
);
    localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [HART_W-1:0]    in_hart;
    logic [XLEN-1:0]      in_pc;
    logic [NUM_HARTS-1:0] flush_hart;

    logic                 out_valid;
    logic                 out_ready;
    logic [HART_W-1:0]    out_hart;
    logic [XLEN-1:0]      out_pc;
    logic [6:0]           out_opcode;
    logic [4:0]           out_rd;
    logic [4:0]           out_rs1;
    logic [4:0]           out_rs2;
    logic [2:0]           out_funct3;
    logic [6:0]           out_funct7;
    logic                 out_rs1_en;
    logic                 out_rs2_en;
    logic                 out_rd_wr;
    logic                 out_mem_en;
    logic                 out_mem_wr;
    logic                 out_csr_en;
    logic                 out_csr_wr;
    logic                 out_jump;
    logic                 out_branch;
    logic                 out_mret;
    logic [XLEN-1:0]      out_imm;
    logic                 out_illegal;

    modport slave (
        input  in_valid, in_inst, in_hart, in_pc, flush_hart, out_ready,
        output in_ready, out_valid, out_hart, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_rs1_en, out_rs2_en, out_rd_wr, out_mem_en,
               out_mem_wr, out_csr_en, out_csr_wr, out_jump, out_branch, out_mret,
               out_imm, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_hart, in_pc, flush_hart, out_ready,
        input  in_ready, out_valid, out_hart, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_rs1_en, out_rs2_en, out_rd_wr, out_mem_en,
               out_mem_wr, out_csr_en, out_csr_wr, out_jump, out_branch, out_mret,
               out_imm, out_illegal
    );

endinterface

// File: rtl/rv_dec_ctrl.sv
// rv_dec_ctrl: purely combinational RV32I decoder.
//   inst (in, 32)   : the instruction word.
//   dec  (out, dec_t): raw opcode, funct3 and funct7; the control enables; the immediate.
//     - The immediate is sign-extended and chosen by opcode. R-type gives 0.
//     - A register index is forced to 0 when its enable is off. Later hazard logic can then
//       compare indices without also checking the enables.
//     - An illegal encoding clears every enable and leaves only the illegal flag set.
module rv_dec_ctrl
    import rv_dec_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    ctrl_t       c;
    logic [31:0] imm;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        c   = '0;
        imm = '0;
        case (opc)
            OPC_LOAD: begin
                c.rs1_en  = 1'b1;
                c.rd_wr   = 1'b1;
                c.mem_en  = 1'b1;
                imm       = imm_i;
                c.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                c.rs1_en  = 1'b1;
                c.rs2_en  = 1'b1;
                c.mem_en  = 1'b1;
                c.mem_wr  = 1'b1;
                imm       = imm_s;
                c.illegal = (f3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                c.rs1_en = 1'b1;
                c.rd_wr  = 1'b1;
                imm      = imm_i;
                // Shift-immediate forms reuse the funct7 slot and must carry a valid shift type.
                if (f3 == F3_SLL)
                    c.illegal = (f7 != F7_BASE);
                else if (f3 == F3_SRL_SRA)
                    c.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            OPC_OP: begin
                c.rs1_en  = 1'b1;
                c.rs2_en  = 1'b1;
                c.rd_wr   = 1'b1;
                // Only SUB and SRA use the alternate funct7.
                c.illegal = !((f7 == F7_BASE) ||
                              ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
            end
            OPC_LUI, OPC_AUIPC: begin
                c.rd_wr = 1'b1;
                imm     = imm_u;
            end
            OPC_JAL: begin
                c.rd_wr = 1'b1;
                c.jump  = 1'b1;
                imm     = imm_j;
            end
            OPC_JALR: begin
                c.rs1_en = 1'b1;
                c.rd_wr  = 1'b1;
                c.jump   = 1'b1;
                imm      = imm_i;
            end
            OPC_BRANCH: begin
                c.rs1_en  = 1'b1;
                c.rs2_en  = 1'b1;
                c.branch  = 1'b1;
                imm       = imm_b;
                c.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_FENCE: begin
                imm = imm_i;
            end
            OPC_SYSTEM: begin
                imm = imm_i;
                if (f3 == F3_PRIV) begin
                    c.mret = (inst == MRET_WORD);
                end else if (f3 == F3_CSR_RSV) begin
                    c.illegal = 1'b1;
                end else begin
                    c.csr_en = 1'b1;
                    c.rd_wr  = 1'b1;
                    // For the immediate CSR forms the rs1 field holds uimm, not a register.
                    c.rs1_en = !f3[2];
                    // CSRRW/CSRRWI always write. Set and clear forms skip the write when the
                    // source is x0 or uimm 0, so a read-only CSR can be read without a fault.
                    c.csr_wr = (f3[1:0] == 2'b01) || (inst[19:15] != 5'd0);
                end
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase

        if (inst[1:0] != 2'b11)
            c.illegal = 1'b1;

        if (c.illegal) begin
            c         = '0;
            c.illegal = 1'b1;
        end
    end

    always_comb begin
        dec        = '0;
        dec.opcode = opc;
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.rd     = c.rd_wr  ? inst[11:7]  : 5'd0;
        dec.rs1    = c.rs1_en ? inst[19:15] : 5'd0;
        dec.rs2    = c.rs2_en ? inst[24:20] : 5'd0;
        dec.ctrl   = c;
        dec.imm    = imm;
    end

endmodule

// File: rtl/rv_dec_stage_mt.sv
// rv_dec_stage_mt: registered, handshaked RV32I decode stage for the multithreaded core.
//   clk  (in) : core clock.
//   rst  (in) : synchronous, active-high reset.
//   bus  (rv_dec_stage_mt_if.slave):
//     - fetch input : in_valid, in_ready, in_inst, in_hart, in_pc.
//     - flush       : flush_hart, a per-hart kill mask.
//     - output      : out_valid, out_ready, and the decoded out_* fields.
// An accepted word appears on out_* one cycle later. The output holds while stalled.
// A flush of a hart discards that hart's words, both at the input and in the stage.
// Optional build macro RV_DEC_SKID_EN:
//   - Adds a skid register.
//   - in_ready becomes a registered !skid_full, so there is no combinational path from
//     out_ready to in_ready.
//   - Without the macro, in_ready is combinational: !out_valid || out_ready || flush of out_hart.
module rv_dec_stage_mt
    import rv_dec_pkg::*;
#(
    parameter int NUM_HARTS = 4,
    parameter int XLEN      = 32
) (
    input  logic             clk,
    input  logic             rst,
    rv_dec_stage_mt_if.slave bus
);

    localparam int HART_W = hart_width(NUM_HARTS);

    if (XLEN != 32) begin : g_xlen_chk
        $error("rv_dec_stage_mt: only XLEN=32 is supported");
    end

    typedef struct packed {
        logic [HART_W-1:0] hart;
        logic [XLEN-1:0]   pc;
        dec_t              dec;
    } entry_t;

    // A hart tag outside 0..NUM_HARTS-1 can never be flushed.
    function automatic logic hart_flushed(input logic [NUM_HARTS-1:0] mask,
                                          input logic [HART_W-1:0]    hart);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_HARTS; i++)
            if (hart == HART_W'(i)) hit = mask[i];
        return hit;
    endfunction

    dec_t   in_dec;
    entry_t in_entry;
    entry_t out_q;
    logic   out_valid_q;
    logic   out_kill;
    logic   in_cap;

    rv_dec_ctrl u_ctrl (
        .inst (bus.in_inst),
        .dec  (in_dec)
    );

    assign in_entry = '{hart: bus.in_hart, pc: bus.in_pc, dec: in_dec};
    assign out_kill = out_valid_q && hart_flushed(bus.flush_hart, out_q.hart);
    // A word from a hart being flushed is still handshaked, but it is never stored.
    assign in_cap   = bus.in_valid && bus.in_ready && !hart_flushed(bus.flush_hart, bus.in_hart);

`ifdef RV_DEC_SKID_EN
    entry_t skid_q;
    logic   skid_valid_q;
    logic   skid_kill;
    logic   out_free;

    assign skid_kill    = skid_valid_q && hart_flushed(bus.flush_hart, skid_q.hart);
    assign out_free     = !out_valid_q || bus.out_ready || out_kill;
    assign bus.in_ready = !skid_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '{hart: '0, pc: '0, dec: dec_nop()};
            skid_q       <= '{hart: '0, pc: '0, dec: dec_nop()};
        end else if (out_free) begin
            // The skid entry is older than anything arriving now, so it goes out first.
            // in_ready is low while the skid is full, so no input can arrive on that path.
            if (skid_valid_q && !skid_kill) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
            end else if (in_cap) begin
                out_q       <= in_entry;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
            skid_valid_q <= 1'b0;
        end else begin
            if (in_cap) begin
                skid_q       <= in_entry;
                skid_valid_q <= 1'b1;
            end else if (skid_kill) begin
                skid_valid_q <= 1'b0;
            end
        end
    end
`else
    assign bus.in_ready = !out_valid_q || bus.out_ready || out_kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '{hart: '0, pc: '0, dec: dec_nop()};
        end else if (in_cap) begin
            out_q       <= in_entry;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready || out_kill) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.out_valid   = out_valid_q;
    assign bus.out_hart    = out_q.hart;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_opcode  = out_q.dec.opcode;
    assign bus.out_rd      = out_q.dec.rd;
    assign bus.out_rs1     = out_q.dec.rs1;
    assign bus.out_rs2     = out_q.dec.rs2;
    assign bus.out_funct3  = out_q.dec.funct3;
    assign bus.out_funct7  = out_q.dec.funct7;
    assign bus.out_rs1_en  = out_q.dec.ctrl.rs1_en;
    assign bus.out_rs2_en  = out_q.dec.ctrl.rs2_en;
    assign bus.out_rd_wr   = out_q.dec.ctrl.rd_wr;
    assign bus.out_mem_en  = out_q.dec.ctrl.mem_en;
    assign bus.out_mem_wr  = out_q.dec.ctrl.mem_wr;
    assign bus.out_csr_en  = out_q.dec.ctrl.csr_en;
    assign bus.out_csr_wr  = out_q.dec.ctrl.csr_wr;
    assign bus.out_jump    = out_q.dec.ctrl.jump;
    assign bus.out_branch  = out_q.dec.ctrl.branch;
    assign bus.out_mret    = out_q.dec.ctrl.mret;
    assign bus.out_imm     = out_q.dec.imm;
    assign bus.out_illegal = out_q.dec.ctrl.illegal;

endmodule

// File: tb/tb_rv_dec_stage_mt.sv
// tb_rv_dec_stage_mt: directed bench for rv_dec_stage_mt in its default configuration.
// The expected values are hand-computed encodings and decodes.
// A negedge monitor checks the PC of every output beat against exp_q, which gives the
// ordering, loss and duplicate checks.
module tb_rv_dec_stage_mt;

    localparam int NUM_HARTS = 4;
    localparam int XLEN      = 32;

    localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093;
    localparam logic [31:0] I_SW_X1_8_X2  = 32'h0011_2423;
    localparam logic [31:0] I_JAL_X1_M4   = 32'hFFDF_F0EF;
    localparam logic [31:0] I_ADDI_X2_7   = 32'h0070_0113;
    localparam logic [31:0] I_ADDI_X3_9   = 32'h0090_0193;
    localparam logic [31:0] I_ADDI_X4_1   = 32'h0010_0213;
    localparam logic [31:0] I_ADDI_X5_2   = 32'h0020_0293;
    localparam logic [31:0] I_MRET        = 32'h3020_0073;
    localparam logic [31:0] I_CSRRS_X5    = 32'h3000_22F3;
    localparam logic [31:0] I_BEQ_M8      = 32'hFE20_8CE3;
    localparam logic [31:0] I_ALL_ONES    = 32'hFFFF_FFFF;
    localparam logic [31:0] I_MUL         = 32'h0231_00B3;
    localparam logic [31:0] I_SUB         = 32'h4031_00B3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    rv_dec_stage_mt_if #(.NUM_HARTS(NUM_HARTS), .XLEN(XLEN)) bus ();

    rv_dec_stage_mt #(.NUM_HARTS(NUM_HARTS), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [1:0] hart,
                         input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_inst  = inst;
        bus.in_hart  = hart;
        bus.in_pc    = pc;
    endtask

    // Sends one word with out_ready held high and returns at the negedge after it lands.
    task automatic send(input logic [31:0] inst, input logic [1:0] hart, input logic [31:0] pc);
        drive(1'b1, inst, hart, pc);
        exp_q.push_back(pc);
        tick();
        drive(1'b0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] enables();
        return {22'd0, bus.out_rs1_en, bus.out_rs2_en, bus.out_rd_wr, bus.out_mem_en,
                bus.out_mem_wr, bus.out_csr_en, bus.out_csr_wr, bus.out_jump,
                bus.out_branch, bus.out_mret};
    endfunction

    // Output-beat scoreboard.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        if (!rst && bus.out_valid && bus.out_ready) begin
            exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check("beat_pc", bus.out_pc, exp_pc);
        end
    end

    initial begin
        rst            = 1'b1;
        bus.flush_hart = '0;
        bus.out_ready  = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid",  32'(bus.out_valid),  32'd0);
        check("rst_opcode", 32'(bus.out_opcode), 32'h13);
        check("rst_ready",  32'(bus.in_ready),   32'd1);

        // Back-to-back stream on hart 0.
        tick();
        bus.out_ready = 1'b1;
        drive(1'b1, I_ADDI_X1_5, 2'd0, 32'h100);
        exp_q.push_back(32'h100);
        tick();
        drive(1'b1, I_SW_X1_8_X2, 2'd0, 32'h104);
        exp_q.push_back(32'h104);
        @(negedge clk);
        check("addi_valid", 32'(bus.out_valid), 32'd1);
        check("addi_imm",   bus.out_imm,        32'd5);
        check("addi_rd",    32'(bus.out_rd),    32'd1);
        check("addi_rdwr",  32'(bus.out_rd_wr), 32'd1);
        tick();
        drive(1'b1, I_JAL_X1_M4, 2'd0, 32'h108);
        exp_q.push_back(32'h108);
        @(negedge clk);
        check("sw_imm",   bus.out_imm,         32'd8);
        check("sw_rdwr",  32'(bus.out_rd_wr),  32'd0);
        check("sw_memwr", 32'(bus.out_mem_wr), 32'd1);
        check("sw_rd",    32'(bus.out_rd),     32'd0);
        check("sw_rs1",   32'(bus.out_rs1),    32'd2);
        tick();
        drive(1'b0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        check("jal_imm",  bus.out_imm,       32'hFFFF_FFFC);
        check("jal_jump", 32'(bus.out_jump), 32'd1);
        check("jal_rd",   32'(bus.out_rd),   32'd1);
        tick();
        @(negedge clk);
        check("stream_idle", 32'(bus.out_valid), 32'd0);

        // Back-pressure: A is held for three cycles while B waits.
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, I_ADDI_X2_7, 2'd0, 32'h200);
        exp_q.push_back(32'h200);
        tick();
        drive(1'b1, I_ADDI_X3_9, 2'd0, 32'h204);
        exp_q.push_back(32'h204);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_imm",   bus.out_imm,         32'd7);
            check("hold_rd",    32'(bus.out_rd),     32'd2);
            check("hold_valid", 32'(bus.out_valid),  32'd1);
            check("hold_ready", 32'(bus.in_ready),   32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        check("after_hold_imm", bus.out_imm, 32'd9);
        tick();
        @(negedge clk);
        check("after_hold_idle", 32'(bus.out_valid), 32'd0);

        // Flush hart 2 while it is stalled in the stage; hart 1 enters in the same cycle.
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, I_ADDI_X4_1, 2'd2, 32'h300);
        tick();
        drive(1'b1, I_ADDI_X5_2, 2'd1, 32'h304);
        bus.flush_hart = 4'b0100;
        exp_q.push_back(32'h304);
        @(negedge clk);
        check("flush_old_hart",  32'(bus.out_hart), 32'd2);
        check("flush_in_ready",  32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 2'd0, 32'h0);
        bus.flush_hart = '0;
        @(negedge clk);
        check("flush_new_hart",  32'(bus.out_hart),  32'd1);
        check("flush_new_pc",    bus.out_pc,         32'h304);
        check("flush_new_valid", 32'(bus.out_valid), 32'd1);
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        tick();

        // A word from a hart under flush is handshaked but dropped.
        drive(1'b1, I_ADDI_X4_1, 2'd3, 32'h308);
        bus.flush_hart = 4'b1000;
        @(negedge clk);
        check("drop_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 2'd0, 32'h0);
        bus.flush_hart = '0;
        @(negedge clk);
        check("drop_valid", 32'(bus.out_valid), 32'd0);
        tick();

        // SYSTEM, BRANCH, illegal and OP decodes.
        send(I_MRET, 2'd0, 32'h400);
        check("mret_mret",    32'(bus.out_mret),    32'd1);
        check("mret_csr_en",  32'(bus.out_csr_en),  32'd0);
        check("mret_rd_wr",   32'(bus.out_rd_wr),   32'd0);
        check("mret_illegal", 32'(bus.out_illegal), 32'd0);
        send(I_CSRRS_X5, 2'd1, 32'h404);
        check("csrrs_csr_en", 32'(bus.out_csr_en), 32'd1);
        check("csrrs_csr_wr", 32'(bus.out_csr_wr), 32'd0);
        check("csrrs_rd_wr",  32'(bus.out_rd_wr),  32'd1);
        check("csrrs_rd",     32'(bus.out_rd),     32'd5);
        send(I_BEQ_M8, 2'd2, 32'h408);
        check("beq_branch", 32'(bus.out_branch), 32'd1);
        check("beq_imm",    bus.out_imm,         32'hFFFF_FFF8);
        check("beq_rd",     32'(bus.out_rd),     32'd0);
        check("beq_rs2",    32'(bus.out_rs2),    32'd2);
        send(I_ALL_ONES, 2'd3, 32'h40C);
        check("ones_illegal", 32'(bus.out_illegal), 32'd1);
        check("ones_valid",   32'(bus.out_valid),   32'd1);
        check("ones_enables", enables(),            32'd0);
        check("ones_rd",      32'(bus.out_rd),      32'd0);
        send(I_MUL, 2'd0, 32'h410);
        check("mul_illegal", 32'(bus.out_illegal), 32'd1);
        check("mul_enables", enables(),            32'd0);
        check("mul_rs1",     32'(bus.out_rs1),     32'd0);
        check("mul_rs2",     32'(bus.out_rs2),     32'd0);
        send(I_SUB, 2'd1, 32'h414);
        check("sub_illegal", 32'(bus.out_illegal), 32'd0);
        check("sub_rd",      32'(bus.out_rd),      32'd1);
        check("sub_rs2",     32'(bus.out_rs2),     32'd3);

        // Reset while a word is stalled in the stage: the word must never appear.
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, I_ADDI_X1_5, 2'd0, 32'h600);
        tick();
        drive(1'b0, 32'h0, 2'd0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid",  32'(bus.out_valid),  32'd0);
        check("mid_rst_opcode", 32'(bus.out_opcode), 32'h13);
        check("mid_rst_imm",    bus.out_imm,         32'd0);
        tick();
        bus.out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
